// File: rtl/sdiv32_seq.sv
// Sequential signed divider: restoring radix-2 core on operand magnitudes,
// one quotient bit per cycle, sign fix-up and special-case flags in a final cycle.
module sdiv32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE (busy low). The accepting edge
  // raises busy; exactly WIDTH+1 edges later done pulses for one cycle with
  // q/r/flags valid, busy drops, and a start in that same cycle is accepted.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic [WIDTH-1:0] min_val;

  // Magnitudes in WIDTH+1 bits so that the most negative operand is representable.
  always_comb begin
    a_ext   = {a[WIDTH-1], a};
    b_ext   = {b[WIDTH-1], b};
    a_mag   = a[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
    b_mag   = b[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;
    min_val = {1'b1, {(WIDTH-1){1'b0}}};
  end

  // Quotient bits shift into dvd_q as dividend bits shift out of its top.
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    ge      = (shifted >= dvs_q);
    q_mag   = dvd_q;
    r_mag   = rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = a_mag[WIDTH-1:0];
          dvs_d   = b_mag;
          a_d     = a;
          qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
          rneg_d  = a[WIDTH-1];
          dz_d    = (b == '0);
          ov_d    = (a == min_val) && (b == '1);
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        rem_d = ge ? (shifted - dvs_q) : shifted;
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // Overflow needs no override: |q| = 2^(WIDTH-1) already reads as the minimum value.
        if (dz_q) begin
          q_d = '1;
          r_d = a_q;
        end else begin
          q_d = qneg_q ? (~q_mag + 1'b1) : q_mag;
          r_d = rneg_q ? (~r_mag + 1'b1) : r_mag;
        end
        dbz_d   = dz_q;
        ovf_d   = ov_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q           = q_q;
  assign r           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign state_dbg   = state_q;

endmodule
